// File: rtl/aes128_dec_core_if.sv
// Purpose : start/ready/done handshake and data bus of the AES-128 decrypt core.
// Latency : n/a (signal bundle only).
// Backpressure: start_i is only honoured while ready_o is high; nothing is queued.
//
// Signals:
//   start_i        start request (master -> core)
//   key_i          128-bit cipher key, [127:120] is byte 0
//   cipher_text_i  128-bit ciphertext, same byte order
//   plain_text_o   128-bit decrypted block (core -> master), registered
//   ready_o        core idle and able to accept start_i
//   done_o         one-cycle pulse, plain_text_o updated
interface aes128_dec_core_if;
    logic         start_i;
    logic [127:0] key_i;
    logic [127:0] cipher_text_i;
    logic [127:0] plain_text_o;
    logic         ready_o;
    logic         done_o;

    modport master (
        output start_i,
        output key_i,
        output cipher_text_i,
        input  plain_text_o,
        input  ready_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  key_i,
        input  cipher_text_i,
        output plain_text_o,
        output ready_o,
        output done_o
    );
endinterface

// File: rtl/aes128_dec_core.sv
// Purpose : iterative AES-128 inverse cipher, one round per cycle, round keys
//           regenerated backwards from rk10 on the fly.
// Latency : start accepted at E0 -> done_o after E22 (after E12 on a key-cache hit).
// Backpressure: ready_o low while busy; start_i during that time is dropped, not queued.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any operation in flight
//   bus    aes128_dec_core_if.slave (start_i, key_i, cipher_text_i,
//          plain_text_o, ready_o, done_o)
// Parameter OUT_HOLD: 1 = plain_text_o holds the last result until the next
//          done; 0 = plain_text_o clears to 0 when a start is accepted.
// Optional build macro AES_DEC_KEY_CACHE_EN: remembers the last key and its
//          rk10 so a repeated key skips the forward key expansion.
module aes128_dec_core #(
    parameter bit OUT_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    aes128_dec_core_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_INIT   = 3'd2,
        S_ROUND  = 3'd3,
        S_FIN    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers. The S-boxes are computed from the field inverse and
    // the affine map rather than stored as tables; they are still pure
    // combinational lookups.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        // RotWord then SubWord
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] forward_expand(input logic [127:0] k, input logic [7:0] rc_b);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc_b, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one forward step: recover the previous round key from the current one.
    function automatic logic [127:0] inverse_expand(input logic [127:0] k, input logic [7:0] rc_b);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc_b, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         st,      st_nxt;
    logic [127:0]   blk,     blk_nxt;     // cipher state
    logic [127:0]   rk,      rk_nxt;      // current round key
    logic [3:0]     rc,      rc_nxt;      // round counter / rcon index
    logic [127:0]   pt_q,    pt_nxt;
    logic           ready_q, ready_nxt;
    logic           done_q,  done_nxt;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0]   cache_key,  cache_key_nxt;
    logic [127:0]   cache_rk10, cache_rk10_nxt;
    logic           cache_vld,  cache_vld_nxt;
`endif

    // Shared datapath: one inverse round and one key step of each direction,
    // both indexed by rc (rc is 10 in INIT, so rk_inv there yields rk9).
    logic [127:0] blk_isb;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;

    assign blk_isb = inv_sub_bytes(inv_shift_rows(blk));
    assign rk_fwd  = forward_expand(rk, rcon(rc));
    assign rk_inv  = inverse_expand(rk, rcon(rc));

    always_comb begin
        st_nxt    = st;
        blk_nxt   = blk;
        rk_nxt    = rk;
        rc_nxt    = rc;
        pt_nxt    = pt_q;
        ready_nxt = ready_q;
        done_nxt  = done_q;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_key_nxt  = cache_key;
        cache_rk10_nxt = cache_rk10;
        cache_vld_nxt  = cache_vld;
`endif

        case (st)
            S_IDLE: begin
                done_nxt = 1'b0;
                if (bus.start_i && ready_q) begin
                    blk_nxt   = bus.cipher_text_i;
                    ready_nxt = 1'b0;
                    if (!OUT_HOLD) pt_nxt = '0;
`ifdef AES_DEC_KEY_CACHE_EN
                    // The key is noted now and valid dropped until DONE, so
                    // the key/rk10 pair only becomes usable once the
                    // operation completes; rk10 itself is written in INIT.
                    cache_key_nxt = bus.key_i;
                    cache_vld_nxt = 1'b0;
                    if (cache_vld && (bus.key_i == cache_key)) begin
                        rk_nxt = cache_rk10;
                        rc_nxt = 4'd10;
                        st_nxt = S_INIT;
                    end else begin
                        rk_nxt = bus.key_i;
                        rc_nxt = 4'd1;
                        st_nxt = S_KEYEXP;
                    end
`else
                    rk_nxt = bus.key_i;
                    rc_nxt = 4'd1;
                    st_nxt = S_KEYEXP;
`endif
                end
            end

            S_KEYEXP: begin
                rk_nxt = rk_fwd;
                if (rc == 4'd10) begin
                    st_nxt = S_INIT;      // rk10 formed, rc stays at 10
                end else begin
                    rc_nxt = rc + 4'd1;
                end
            end

            S_INIT: begin
                blk_nxt = blk ^ rk;
                rk_nxt  = rk_inv;
                rc_nxt  = 4'd9;
                st_nxt  = S_ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                cache_rk10_nxt = rk;
`endif
            end

            S_ROUND: begin
                blk_nxt = inv_mix_columns(blk_isb ^ rk);
                rk_nxt  = rk_inv;
                rc_nxt  = rc - 4'd1;
                if (rc == 4'd1) st_nxt = S_FIN;   // that round consumed rk1; rk0 now loaded
            end

            S_FIN: begin
                blk_nxt = blk_isb ^ rk;
                st_nxt  = S_DONE;
            end

            S_DONE: begin
                pt_nxt    = blk;
                done_nxt  = 1'b1;
                ready_nxt = 1'b1;
                rc_nxt    = 4'd0;
                st_nxt    = S_IDLE;
`ifdef AES_DEC_KEY_CACHE_EN
                cache_vld_nxt = 1'b1;
`endif
            end

            default: begin
                st_nxt    = S_IDLE;
                ready_nxt = 1'b1;
                done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            blk     <= '0;
            rk      <= '0;
            rc      <= '0;
            pt_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            st      <= st_nxt;
            blk     <= blk_nxt;
            rk      <= rk_nxt;
            rc      <= rc_nxt;
            pt_q    <= pt_nxt;
            ready_q <= ready_nxt;
            done_q  <= done_nxt;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key  <= '0;
            cache_rk10 <= '0;
            cache_vld  <= 1'b0;
        end else begin
            cache_key  <= cache_key_nxt;
            cache_rk10 <= cache_rk10_nxt;
            cache_vld  <= cache_vld_nxt;
        end
    end
`endif

    assign bus.plain_text_o = pt_q;
    assign bus.ready_o      = ready_q;
    assign bus.done_o       = done_q;

endmodule

// File: doc/aes128_dec_core.md
Name: aes128_dec_core

Overview:
Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It is the decrypt-side counterpart to the team's AES-128 encryption core and uses the same start/ready/done handshake.
- Accepts a 128-bit cipher key and ciphertext.
- Expands the key forward to round key 10.
- Runs the 10 inverse rounds, regenerating round keys backwards on the fly.
- Presents the plaintext with a one-cycle done pulse.

Parameters:
OUT_HOLD, 1, 1: plain_text_o holds the last result until the next DONE; 0: plain_text_o clears to 0 when a new start is accepted.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  start request; accepted only in IDLE with ready_o=1
key_i  input  128  cipher key; [127:120] is byte 0 (FIPS-197 string order)
cipher_text_i  input  128  ciphertext, same byte order
plain_text_o  output  128  decrypted block, registered
ready_o  output  1  high when idle and able to accept start_i
done_o  output  1  one-cycle pulse: plain_text_o is valid/updated

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready_o=1, done_o=0, plain_text_o=0, internal state/key registers=0, round counter=0.
- Reset mid-operation aborts immediately. No output is produced, and the core returns to IDLE with reset values.
- FSM states: IDLE, KEYEXP, INIT, ROUND, FIN, DONE. Any illegal encoding goes to IDLE.
- IDLE: done_o<=0.
  - If start_i: capture key_i into the round-key register and cipher_text_i into the state register; rc<=1; ready_o<=0; go to KEYEXP.
  - If OUT_HOLD=0, also plain_text_o<=0.
- KEYEXP: each cycle, rk <= forward_expand(rk, rcon[rc]); rc++.
  - 10 cycles. After rk10 is formed, go to INIT with rc=10.
- INIT: state <= state ^ rk10; rk <= inverse_expand(rk10, rcon[10]) (= rk9); rc<=9; go to ROUND.
- ROUND: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk); rk <= inverse_expand(rk, rcon[rc]); rc--.
  - 9 cycles, for rounds 9..1.
  - Leave for FIN after the round that uses rk1.
- Inverse key step:
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
- FIN: state <= InvSubBytes(InvShiftRows(state)) ^ rk0 (no InvMixColumns); go to DONE.
- DONE: plain_text_o<=state; done_o<=1; ready_o<=1; rc<=0; go to IDLE.
- Latency: start accepted at edge E0 → done_o high in the cycle after edge E22, low again after E23.
  - A start_i held high at E23 begins a new operation; back-to-back throughput is 1 block per 23 cycles.
- start_i while ready_o=0 is ignored. No queuing, and inputs are not resampled.
- key_i and cipher_text_i are sampled only at the accepting edge; later changes have no effect.
- rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- InvSubBytes/SubWord are combinational lookups; the S-box and inverse S-box are separate functions.
- One round per cycle, with no multi-cycle sub-blocks.

Optional Feature:
AES_DEC_KEY_CACHE_EN
- Defined:
  - Adds a 128-bit cached-key register, a 128-bit cached-rk10 register, and a valid bit (reset 0).
  - DONE writes key/rk10 into the cache and sets valid.
  - In IDLE, if start_i && valid && key_i==cached key: load rk<=cached rk10 and go straight to INIT. Latency becomes 12 edges (done after E12).
  - A key mismatch takes the normal KEYEXP path.
  - Reset clears valid.
- Undefined: no cache registers; latency is always 22.

Test Plan:
1. Reset, then key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a, start 1 cycle → done_o after E22, plain_text_o=00112233445566778899aabbccddeeff, ready_o=1.
2. key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32 → plain_text_o=3243f6a8885a308d313198a2e0370734. Inputs are changed to random values after E0 with no effect on the result.
3. start_i pulsed at E5 and E15 of an operation → ignored: a single done_o pulse at E22 with the correct plaintext, and the next op starts only on a start seen at ≥E23.
4. rst_n=0 asserted at E12 mid-ROUND → outputs immediately 0/ready_o=1/done_o=0. A subsequent vector 1 completes correctly in 22 cycles.
5. AES_DEC_KEY_CACHE_EN defined: vector 1 twice back-to-back → first latency 22, second 12, same plaintext. Then vector 2 (new key) → latency 22, correct plaintext.
6. OUT_HOLD=0: after vector 1, start vector 2 → plain_text_o reads 0 from E1 until E22, then 3243f6a8...0734. OUT_HOLD=1: it holds 00112233...eeff until E22.
